// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces quotient on lo and remainder on hi; stalls the pipeline while busy.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divMag;
    logic             negQ;
    logic             negR;

    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic             lastIter;

    // rem < divMag always holds, so the shifted remainder minus divMag stays
    // within a signed WIDTH+1 range and diff[WIDTH] is a valid sign bit.
    always_comb begin
        aMag     = (signed_div & a[WIDTH-1]) ? -a : a;
        bMag     = (signed_div & b[WIDTH-1]) ? -b : b;
        remShift = {rem, quo[WIDTH-1]};
        diff     = remShift - {1'b0, divMag};
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end else begin
            remNext = remShift[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end
        lastIter = (cnt == CW'(WIDTH - 1));
    end

    assign div_stall = ((state == IDLE) & start & ~cancel) | (state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            divMag       <= '0;
            negQ         <= 1'b0;
            negR         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rem    <= '0;
                            quo    <= aMag;
                            divMag <= bMag;
                            negQ   <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            negR   <= signed_div & a[WIDTH-1];
                            cnt    <= '0;
                            state  <= CALC;
                        end
                    end
                    CALC: begin
                        rem <= remNext;
                        quo <= quoNext;
                        cnt <= cnt + CW'(1);
                        if (lastIter) begin
                            lo           <= negQ ? -quoNext : quoNext;
                            hi           <= negR ? -remNext : remNext;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    // start is still high for the finished instruction here
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS DIV/DIVU cases, random
// operands against a behavioural model, stall timing, cancel and reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    exp_t expQ[$];

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_div(signed_div),
        .cancel(cancel),
        .a(a),
        .b(b),
        .div_stall(div_stall),
        .result_valid(result_valid),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic sgn);
        exp_t  e;
        longint sa;
        longint sb;
        if (bv == 32'd0) begin
            e.hi = av;
            e.lo = (sgn && av[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa   = longint'($signed(av));
            sb   = longint'($signed(bv));
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
        end else begin
            e.lo = av / bv;
            e.hi = av % bv;
        end
        return e;
    endfunction

    // Drives one divide the way the stalled pipeline does: start held until
    // the DONE cycle ends, then dropped. Observes a few cycles past the pulse.
    task automatic runDiv(input logic [31:0] av, input logic [31:0] bv, input logic sgn,
                          input bit wiggle, output int stallCnt, output int pulseCnt,
                          output int pulseCycle, output logic [31:0] obsLo,
                          output logic [31:0] obsHi);
        @(posedge clk); #1;
        start = 1'b1; a = av; b = bv; signed_div = sgn;
        stallCnt = 0; pulseCnt = 0; pulseCycle = -1; obsLo = '0; obsHi = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (div_stall) stallCnt++;
            if (result_valid) begin
                pulseCnt++;
                if (pulseCycle < 0) begin
                    pulseCycle = cyc;
                    obsLo = lo;
                    obsHi = hi;
                end
            end
            @(posedge clk); #1;
            if (wiggle) begin
                a = $urandom;
                b = $urandom;
            end
            if (pulseCycle >= 0 && cyc == pulseCycle) start = 1'b0;
            if (pulseCycle >= 0 && cyc >= pulseCycle + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
        #12;
        tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", result_valid); end
        tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", div_stall); end
        #8 rst = 1'b0;
    endtask

    task automatic test_divu_basic;
        int sc, pc, cyc;
        logic [31:0] ol, oh;
        exp_t e;
        expQ.push_back('{lo: 32'd14, hi: 32'd2});
        runDiv(32'd100, 32'd7, 1'b0, 1'b0, sc, pc, cyc, ol, oh);
        tests++; if (sc != 33) begin fails++; $display("FAIL divu_stall_cycles got %0d want 33", sc); end
        tests++; if (pc != 1) begin fails++; $display("FAIL divu_pulse_count got %0d want 1", pc); end
        tests++; if (cyc != 33) begin fails++; $display("FAIL divu_pulse_cycle got %0d want 33", cyc); end
        e = expQ.pop_front();
        tests++; if (ol !== e.lo) begin fails++; $display("FAIL divu_lo got %h want %h", ol, e.lo); end
        tests++; if (oh !== e.hi) begin fails++; $display("FAIL divu_hi got %h want %h", oh, e.hi); end
    endtask

    task automatic test_signed_corners;
        vec_t vecs[5];
        int sc, pc, cyc;
        logic [31:0] ol, oh;
        exp_t e;
        vecs[0] = '{a: 32'hFFFF_FFF9, b: 32'd2,          sgn: 1'b1, lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF};
        vecs[1] = '{a: 32'd7,          b: 32'hFFFF_FFFE, sgn: 1'b1, lo: 32'hFFFF_FFFD, hi: 32'd1};
        vecs[2] = '{a: 32'd5,          b: 32'd0,          sgn: 1'b0, lo: 32'hFFFF_FFFF, hi: 32'd5};
        vecs[3] = '{a: 32'hFFFF_FFFB, b: 32'd0,          sgn: 1'b1, lo: 32'd1,          hi: 32'hFFFF_FFFB};
        vecs[4] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, sgn: 1'b1, lo: 32'h8000_0000, hi: 32'd0};
        for (int i = 0; i < 5; i++) begin
            expQ.push_back('{lo: vecs[i].lo, hi: vecs[i].hi});
            runDiv(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, sc, pc, cyc, ol, oh);
            e = expQ.pop_front();
            tests++;
            if (pc != 1) begin
                fails++; $display("FAIL corner%0d_pulse got %0d want 1", i, pc);
            end
            tests++; if (ol !== e.lo) begin fails++; $display("FAIL corner%0d_lo got %h want %h", i, ol, e.lo); end
            tests++; if (oh !== e.hi) begin fails++; $display("FAIL corner%0d_hi got %h want %h", i, oh, e.hi); end
        end
    endtask

    task automatic test_random;
        int sc, pc, cyc;
        logic [31:0] ol, oh, av, bv;
        logic sgn;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            av  = $urandom;
            bv  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            sgn = i[0];
            expQ.push_back(model(av, bv, sgn));
            runDiv(av, bv, sgn, 1'b0, sc, pc, cyc, ol, oh);
            e = expQ.pop_front();
            tests++; if (ol !== e.lo || oh !== e.hi || pc != 1) begin
                fails++;
                $display("FAIL random%0d a=%h b=%h s=%b got lo=%h hi=%h pulses=%0d want lo=%h hi=%h",
                         i, av, bv, sgn, ol, oh, pc, e.lo, e.hi);
            end
        end
    endtask

    task automatic test_operand_hold;
        int sc, pc, cyc;
        logic [31:0] ol, oh;
        exp_t e;
        expQ.push_back(model(32'hFFFF_F000, 32'd13, 1'b1));
        runDiv(32'hFFFF_F000, 32'd13, 1'b1, 1'b1, sc, pc, cyc, ol, oh);
        e = expQ.pop_front();
        tests++; if (pc != 1) begin fails++; $display("FAIL hold_pulse_count got %0d want 1", pc); end
        tests++; if (sc != 33) begin fails++; $display("FAIL hold_stall_cycles got %0d want 33", sc); end
        tests++; if (ol !== e.lo) begin fails++; $display("FAIL hold_lo got %h want %h", ol, e.lo); end
        tests++; if (oh !== e.hi) begin fails++; $display("FAIL hold_hi got %h want %h", oh, e.hi); end
    endtask

    task automatic test_back_to_back;
        int pulseAt[2];
        logic [31:0] capLo[2];
        logic [31:0] capHi[2];
        int np;
        int lowStall;
        exp_t e;
        np = 0; lowStall = 0; pulseAt[0] = -1; pulseAt[1] = -1;
        expQ.push_back('{lo: 32'd14, hi: 32'd2});
        expQ.push_back('{lo: 32'd3, hi: 32'd0});
        @(posedge clk); #1;
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (np < 2 && !div_stall && !result_valid) lowStall++;
            if (np < 2 && !div_stall && result_valid && np == 1) lowStall += 0;
            if (np < 1 && !div_stall && result_valid) lowStall++;
            if (result_valid && np < 2) begin
                pulseAt[np] = cyc; capLo[np] = lo; capHi[np] = hi; np++;
            end
            @(posedge clk); #1;
            if (np == 1 && cyc == pulseAt[0]) begin a = 32'd9; b = 32'd3; end
            if (np == 2 && cyc == pulseAt[1]) start = 1'b0;
            if (np == 2 && cyc >= pulseAt[1] + 2) break;
        end
        start = 1'b0;
        tests++; if (np != 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", np); end
        tests++; if (pulseAt[1] - pulseAt[0] != 34) begin
            fails++; $display("FAIL b2b_spacing got %0d want 34", pulseAt[1] - pulseAt[0]);
        end
        tests++; if (lowStall != 1) begin fails++; $display("FAIL b2b_stall_low got %0d want 1", lowStall); end
        for (int i = 0; i < 2; i++) begin
            e = expQ.pop_front();
            tests++; if (capLo[i] !== e.lo || capHi[i] !== e.hi) begin
                fails++;
                $display("FAIL b2b_result%0d got lo=%h hi=%h want lo=%h hi=%h", i, capLo[i], capHi[i], e.lo, e.hi);
            end
        end
    endtask

    task automatic test_cancel;
        int sc, pc, cyc;
        logic [31:0] ol, oh;
        exp_t e;
        expQ.push_back('{lo: 32'd14, hi: 32'd2});
        runDiv(32'd100, 32'd7, 1'b0, 1'b0, sc, pc, cyc, ol, oh);
        e = expQ.pop_front();
        tests++; if (ol !== e.lo || oh !== e.hi) begin
            fails++; $display("FAIL cancel_pre got lo=%h hi=%h want lo=%h hi=%h", ol, oh, e.lo, e.hi);
        end
        @(posedge clk); #1;
        start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        cancel = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b0;
        sc = 0; pc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stall) sc++;
            if (result_valid) pc++;
        end
        tests++; if (sc != 0) begin fails++; $display("FAIL cancel_stall got %0d want 0", sc); end
        tests++; if (pc != 0) begin fails++; $display("FAIL cancel_pulse got %0d want 0", pc); end
        tests++; if (lo !== e.lo || hi !== e.hi) begin
            fails++; $display("FAIL cancel_hold got lo=%h hi=%h want lo=%h hi=%h", lo, hi, e.lo, e.hi);
        end
    endtask

    task automatic test_reset_midcalc;
        int sc, pc, cyc;
        logic [31:0] ol, oh;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b0;
        #2;
        tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL rst_async_stall got %b want 0", div_stall); end
        tests++; if (lo !== 32'd0 || hi !== 32'd0) begin
            fails++; $display("FAIL rst_async_hilo got lo=%h hi=%h want 0", lo, hi);
        end
        @(negedge clk);
        rst = 1'b0;
        sc = 0; pc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stall) sc++;
            if (result_valid) pc++;
        end
        tests++; if (sc != 0 || pc != 0) begin
            fails++; $display("FAIL rst_idle got stalls=%0d pulses=%0d want 0 0", sc, pc);
        end
        expQ.push_back('{lo: 32'd14, hi: 32'd2});
        runDiv(32'd100, 32'd7, 1'b0, 1'b0, sc, pc, cyc, ol, oh);
        e = expQ.pop_front();
        tests++; if (pc != 1 || sc != 33 || ol !== e.lo || oh !== e.hi) begin
            fails++;
            $display("FAIL rst_after got lo=%h hi=%h pulses=%0d stalls=%0d want lo=%h hi=%h 1 33",
                     ol, oh, pc, sc, e.lo, e.hi);
        end
    endtask

    initial begin
        test_reset;
        test_divu_basic;
        test_signed_corners;
        test_random;
        test_operand_hold;
        test_back_to_back;
        test_cancel;
        test_reset_midcalc;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring integer divider for the execute stage of the five-stage MIPS pipeline. It executes DIV and DIVU and produces the quotient (LO) and remainder (HI) for the HI/LO write path. While it works it drives `div_stall`, which the hazard unit consumes as `div_stallE` to freeze F/D/E/M/W. Operands are captured once, so operand changes during a stall are ignored.

## Interface
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  DIV/DIVU instruction present in E (`divE`); level, held high by the stalled pipeline.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `cancel`  in  1  abort in-flight divide (exception/flush); highest priority after `rst`.
- `a`  in  WIDTH  dividend (rs value after E forwarding).
- `b`  in  WIDTH  divisor (rt value after E forwarding).
- `div_stall`  out  1  to hazard `div_stallE`; combinational.
- `result_valid`  out  1  one-cycle pulse; `hi`/`lo` are updated and valid this cycle.
- `hi`  out  WIDTH  remainder, registered.
- `lo`  out  WIDTH  quotient, registered.

## Operation
- States: IDLE, CALC, DONE. Counter `cnt` is $clog2(WIDTH)+1 bits.
- **IDLE**
  - `start & ~cancel`: latch the operand magnitudes. Latch `neg_q = signed_div & (a[MSB]^b[MSB])` and `neg_r = signed_div & a[MSB]`.
  - Magnitude: `|x| = (signed_div & x[MSB]) ? -x : x`.
  - Load `{rem, quo} = {0, |a|}`, `cnt = 0`, then go to CALC.
- **CALC**, one iteration per cycle:
  - Shift `{rem, quo}` left by 1.
  - Compute `diff = rem - |b|` in WIDTH+1 bits.
  - If `diff` is non-negative: `rem = diff` and `quo[0] = 1`. Otherwise `quo[0] = 0`.
  - `cnt++`. After the WIDTH-th iteration, go to DONE.
- Fix-up on the CALC→DONE edge:
  - `lo <= neg_q ? -quo : quo`.
  - `hi <= neg_r ? -rem : rem`.
  - `result_valid <= 1`.
- **DONE**: lasts one cycle, then goes to IDLE unconditionally.
  - `start` is still high for the same instruction here and must NOT restart the divide.
- `div_stall = (IDLE & start & ~cancel) | CALC`. It is 0 in DONE, so the instruction leaves E at the end of the DONE cycle.
- `cancel` in CALC or DONE: go to IDLE next cycle. `hi`/`lo` are unchanged and there is no `result_valid` pulse.
- Divide by zero (`b == 0`) is not special-cased; results follow from the algorithm.
  - DIVU: `lo = all-ones`, `hi = a`.
  - DIV: `lo = a<0 ? 1 : all-ones`, `hi = a`.
- Signed overflow (`0x80000000 / -1`): `lo = 0x80000000`, `hi = 0`.
- `hi`/`lo` hold their last value between results.

## Timing
- Reset values:
  - State = IDLE, `cnt` = 0, `rem`/`quo` = 0.
  - `hi` = `lo` = 0, `result_valid` = 0.
  - `div_stall` = 0 (with `start` low).
- Reset is asynchronous and may arrive mid-CALC. The unit returns to IDLE immediately; no partial result and no pulse.
- Latency: `start` is first seen in IDLE in cycle 0. CALC runs in cycles 1..WIDTH. DONE is cycle WIDTH+1.
- `div_stall` is high in cycles 0..WIDTH: 33 cycles for WIDTH=32.
- `result_valid` and the new `hi`/`lo` are visible in cycle WIDTH+1.
- Back-to-back divides: DONE → IDLE. If a new divide is in E, `start` is seen in IDLE one cycle after DONE. No gap cycle exists inside the unit beyond DONE.
- `start` deasserting during CALC, e.g. from an upstream flush without `cancel`: the divide still completes and pulses `result_valid`.

## Test plan
- DIVU `a=100`, `b=7`: `div_stall` high for exactly 33 cycles; then `lo=14`, `hi=2`, with a `result_valid` pulse of 1 cycle.
- DIV `a=-7` (0xFFFFFFF9), `b=2`: `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. Repeat with `a=7`, `b=-2`: `lo=0xFFFFFFFD`, `hi=1`.
- Divide-by-zero and overflow:
  - DIVU `5/0`: `lo=0xFFFFFFFF`, `hi=5`.
  - DIV `-5/0`: `lo=1`, `hi=0xFFFFFFFB`.
  - DIV `0x80000000/0xFFFFFFFF`: `lo=0x80000000`, `hi=0`.
- Change `a`/`b` every cycle during CALC: the result matches the operands latched in cycle 0. Hold `start` high through DONE: exactly one pulse, and no restart.
- Back-to-back `100/7` then `9/3`:
  - Two pulses, 34 cycles apart.
  - Second result `lo=3`, `hi=0`.
  - `div_stall` low only in the DONE cycle between them.
- Assert `cancel` at CALC cycle 10, then separately assert `rst` at CALC cycle 20:
  - Both return to IDLE with no pulse and no stall.
  - `hi`/`lo` are unchanged after cancel and 0 after reset.
  - A following `100/7` completes normally.
